// File: rtl/bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bus_arbiter_pkg
//   Shared constants and types for the system-bus master arbiter:
//   master count and index width, owner index constants, arbiter FSM state
//   encodings, the active-low ENABLE_/DISABLE_ levels and a helper that
//   builds a one-hot active-low grant vector from an owner index.
// ---------------------------------------------------------------------------
package bus_arbiter_pkg;

  // Number of bus masters and width of a master index.
  localparam int BUS_MASTER_CH      = 4;
  localparam int BUS_MASTER_INDEX_W = 2;

  // Master index bus type.
  typedef logic [BUS_MASTER_INDEX_W-1:0] bus_master_index_t;

  // Owner index constants.
  localparam bus_master_index_t BUS_OWNER_MASTER_0 = 2'd0;
  localparam bus_master_index_t BUS_OWNER_MASTER_1 = 2'd1;
  localparam bus_master_index_t BUS_OWNER_MASTER_2 = 2'd2;
  localparam bus_master_index_t BUS_OWNER_MASTER_3 = 2'd3;

  // Arbiter state encodings. Two bits wide so that the unused codes are
  // real, reachable-by-upset values that the FSM default arm recovers from.
  typedef enum logic [1:0] {
    BUS_ARB_IDLE  = 2'b00,
    BUS_ARB_OWNED = 2'b01
  } bus_arb_state_t;

  // Active-low request/grant levels.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Active-low grant vector with only the indexed master enabled.
  function automatic logic [BUS_MASTER_CH-1:0] grant_vec(input bus_master_index_t idx);
    logic [BUS_MASTER_CH-1:0] v;
    v      = {BUS_MASTER_CH{DISABLE_}};
    v[idx] = ENABLE_;
    return v;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// bus_arbiter_if
//   Request/grant handshake between the four bus masters and the arbiter,
//   plus the arbiter status that the bus master mux consumes.
//
//   m0Req_..m3Req_    active-low bus requests (masters -> arbiter)
//   m0Grnt_..m3Grnt_  active-low registered grants (arbiter -> masters)
//   owner             index of the current owner, valid while busOwned
//   busOwned          high while one grant is asserted
//   holdErr           sticky over-hold flag for the current tenure
//
//   Modports:
//     slave  - arbiter side (takes requests, drives grants/status)
//     master - requester side (drives requests, observes grants/status)
// ---------------------------------------------------------------------------
interface bus_arbiter_if;

  logic m0Req_;
  logic m1Req_;
  logic m2Req_;
  logic m3Req_;

  logic m0Grnt_;
  logic m1Grnt_;
  logic m2Grnt_;
  logic m3Grnt_;

  bus_arbiter_pkg::bus_master_index_t owner;
  logic                               busOwned;
  logic                               holdErr;

  modport slave (
    input  m0Req_, m1Req_, m2Req_, m3Req_,
    output m0Grnt_, m1Grnt_, m2Grnt_, m3Grnt_,
    output owner, busOwned, holdErr
  );

  modport master (
    output m0Req_, m1Req_, m2Req_, m3Req_,
    input  m0Grnt_, m1Grnt_, m2Grnt_, m3Grnt_,
    input  owner, busOwned, holdErr
  );

endinterface

// File: rtl/bus_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// bus_arb_rr_pick
//   Purely combinational round-robin selector. Starting at start_idx and
//   walking upward modulo 4, returns the first master whose active-low
//   request is asserted, optionally skipping one excluded index.
//
//   req_n       4-bit active-low request vector (bit i = master i)
//   start_idx   first index to examine
//   excl_idx    index to ignore when excl_en is high
//   excl_en     enables the exclusion
//   pick_idx    winning index (equals start_idx when nothing is pending)
//   pick_valid  high when some eligible request was found
// ---------------------------------------------------------------------------
module bus_arb_rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [BUS_MASTER_CH-1:0] req_n,
  input  bus_master_index_t        start_idx,
  input  bus_master_index_t        excl_idx,
  input  logic                     excl_en,
  output bus_master_index_t        pick_idx,
  output logic                     pick_valid
);

  // Candidate at offset gi from the start position, and whether it may win.
  bus_master_index_t        cand_idx [BUS_MASTER_CH];
  logic [BUS_MASTER_CH-1:0] cand_ok;

  genvar gi;
  generate
    for (gi = 0; gi < BUS_MASTER_CH; gi++) begin : g_cand
      // 2-bit addition wraps naturally, giving the modulo-4 walk.
      assign cand_idx[gi] = start_idx + BUS_MASTER_INDEX_W'(gi);
      assign cand_ok[gi]  = (req_n[cand_idx[gi]] == ENABLE_) &&
                            !(excl_en && (cand_idx[gi] == excl_idx));
    end
  endgenerate

  // Scan from the farthest offset down so the nearest eligible one wins.
  always_comb begin
    pick_idx   = start_idx;
    pick_valid = 1'b0;
    for (int i = BUS_MASTER_CH - 1; i >= 0; i--) begin
      if (cand_ok[i]) begin
        pick_idx   = cand_idx[i];
        pick_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//   Round-robin owner arbiter for the shared system bus. Four masters
//   request with active-low Req_ lines; the arbiter returns one registered
//   active-low grant, the current owner index (which steers the master mux
//   driving sAddr to the slave decoder) and a sticky over-hold flag raised
//   when an owner keeps the bus for MAX_HOLD cycles while others wait.
//
//   Ports:
//     clk     system clock, rising-edge active
//     reset_  asynchronous active-low reset
//     bus     bus_arbiter_if.slave: requests in; grants, owner, busOwned,
//             holdErr out (all registered)
//
//   Parameters:
//     MAX_HOLD  owned cycles before holdErr may assert (2..255)
// ---------------------------------------------------------------------------
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16
)(
  input  logic          clk,
  input  logic          reset_,
  bus_arbiter_if.slave  bus
);

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  // Architectural state.
  bus_arb_state_t           state_reg,      state_next;
  logic [BUS_MASTER_CH-1:0] grnt_reg,       grnt_next;
  bus_master_index_t        owner_reg,      owner_next;
  bus_master_index_t        last_owner_reg, last_owner_next;
  logic                     bus_owned_reg,  bus_owned_next;
  logic                     hold_err_reg,   hold_err_next;
  logic [7:0]               hold_cnt_reg,   hold_cnt_next;

  // Round-robin selection.
  logic [BUS_MASTER_CH-1:0] req_n;
  bus_master_index_t        pick_idx;
  logic                     pick_valid;
  logic [7:0]               hold_cnt_inc;

  assign req_n = {bus.m3Req_, bus.m2Req_, bus.m1Req_, bus.m0Req_};

  // While owned, lastOwner equals owner, so the search starts just after the
  // current owner and the owner itself is excluded: the pick is "the next
  // other requester". In IDLE nobody is excluded.
  bus_arb_rr_pick u_rr_pick (
    .req_n      (req_n),
    .start_idx  (last_owner_reg + 2'd1),
    .excl_idx   (owner_reg),
    .excl_en    (state_reg == BUS_ARB_OWNED),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  // Saturating tenure counter.
  assign hold_cnt_inc = (hold_cnt_reg >= HOLD_MAX) ? HOLD_MAX : hold_cnt_reg + 8'd1;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_reg      <= BUS_ARB_IDLE;
      grnt_reg       <= {BUS_MASTER_CH{DISABLE_}};
      owner_reg      <= BUS_OWNER_MASTER_0;
      last_owner_reg <= BUS_OWNER_MASTER_3;  // master 0 first after reset
      bus_owned_reg  <= 1'b0;
      hold_err_reg   <= 1'b0;
      hold_cnt_reg   <= 8'd0;
    end else begin
      state_reg      <= state_next;
      grnt_reg       <= grnt_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      bus_owned_reg  <= bus_owned_next;
      hold_err_reg   <= hold_err_next;
      hold_cnt_reg   <= hold_cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    grnt_next       = grnt_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    bus_owned_next  = bus_owned_reg;
    hold_err_next   = hold_err_reg;
    hold_cnt_next   = hold_cnt_reg;

    case (state_reg)
      BUS_ARB_IDLE: begin
        if (pick_valid) begin
          state_next      = BUS_ARB_OWNED;
          grnt_next       = grant_vec(pick_idx);
          owner_next      = pick_idx;
          last_owner_next = pick_idx;
          bus_owned_next  = 1'b1;
          hold_cnt_next   = 8'd0;
          hold_err_next   = 1'b0;
        end
      end

      BUS_ARB_OWNED: begin
        if (req_n[owner_reg] == ENABLE_) begin
          // Owner keeps the bus; never preempted. Flag only when someone
          // else is actually waiting once the limit is reached.
          hold_cnt_next = hold_cnt_inc;
          if ((hold_cnt_inc == HOLD_MAX) && pick_valid)
            hold_err_next = 1'b1;
        end else if (pick_valid) begin
          // Direct handover: old grant drops and new grant rises together.
          grnt_next       = grant_vec(pick_idx);
          owner_next      = pick_idx;
          last_owner_next = pick_idx;
          hold_cnt_next   = 8'd0;
          hold_err_next   = 1'b0;
        end else begin
          // Release with nobody waiting; owner keeps its last value.
          state_next     = BUS_ARB_IDLE;
          grnt_next      = {BUS_MASTER_CH{DISABLE_}};
          bus_owned_next = 1'b0;
          hold_cnt_next  = 8'd0;
          hold_err_next  = 1'b0;
        end
      end

      default: begin
        state_next     = BUS_ARB_IDLE;
        grnt_next      = {BUS_MASTER_CH{DISABLE_}};
        bus_owned_next = 1'b0;
        hold_cnt_next  = 8'd0;
        hold_err_next  = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs: straight from registers, no request-to-grant combinational path
  // -------------------------------------------------------------------------
  always_comb begin
    bus.m0Grnt_  = grnt_reg[0];
    bus.m1Grnt_  = grnt_reg[1];
    bus.m2Grnt_  = grnt_reg[2];
    bus.m3Grnt_  = grnt_reg[3];
    bus.owner    = owner_reg;
    bus.busOwned = bus_owned_reg;
    bus.holdErr  = hold_err_reg;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//   Directed self-checking bench for bus_arbiter with MAX_HOLD = 16.
//   Request vectors are written {m3,m2,m1,m0}, active-low.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

  logic clk;
  logic reset_;
  int   checks;
  int   failures;

  bus_arbiter_if bus_if ();

  bus_arbiter #(.MAX_HOLD(16)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] r);
    bus_if.m0Req_ = r[0];
    bus_if.m1Req_ = r[1];
    bus_if.m2Req_ = r[2];
    bus_if.m3Req_ = r[3];
  endtask

  // Compare grants, owner, busOwned, holdErr, and that at most one grant is low.
  task automatic check(input string tag, input logic [3:0] eg, input logic [1:0] eo,
                       input logic eb, input logic ee);
    logic [3:0] g;
    g = {bus_if.m3Grnt_, bus_if.m2Grnt_, bus_if.m1Grnt_, bus_if.m0Grnt_};
    checks++;
    assert (g === eg) else begin
      failures++;
      $error("FAIL %s grants observed=%b expected=%b", tag, g, eg);
    end
    checks++;
    assert (bus_if.owner === eo) else begin
      failures++;
      $error("FAIL %s owner observed=%0d expected=%0d", tag, bus_if.owner, eo);
    end
    checks++;
    assert (bus_if.busOwned === eb) else begin
      failures++;
      $error("FAIL %s busOwned observed=%b expected=%b", tag, bus_if.busOwned, eb);
    end
    checks++;
    assert (bus_if.holdErr === ee) else begin
      failures++;
      $error("FAIL %s holdErr observed=%b expected=%b", tag, bus_if.holdErr, ee);
    end
    checks++;
    assert ($countones(~g) <= 1) else begin
      failures++;
      $error("FAIL %s grant_overlap observed=%b expected=at_most_one_low", tag, g);
    end
    $display("step %-12s grants=%b owner=%0d busOwned=%b holdErr=%b", tag, g,
             bus_if.owner, bus_if.busOwned, bus_if.holdErr);
  endtask

  logic [3:0] rr_grant [5];
  logic [1:0] rr_owner [5];
  logic [3:0] rr_rel   [5];

  initial begin
    checks   = 0;
    failures = 0;
    rr_grant = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    rr_owner = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    // Request vector on the releasing edge: previous owner high, rest low.
    rr_rel   = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

    reset_ = 1'b0;
    set_req(4'b1111);
    tick();
    tick();
    check("reset", 4'b1111, 2'd0, 1'b0, 1'b0);
    reset_ = 1'b1;

    // Idle with no requests.
    tick();
    check("idle", 4'b1111, 2'd0, 1'b0, 1'b0);

    // m0 and m3 together after reset: m0 wins; nothing changes before the edge.
    set_req(4'b0110);
    #1;
    check("no_comb", 4'b1111, 2'd0, 1'b0, 1'b0);
    tick();
    check("m0_grant", 4'b1110, 2'd0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("m0_hold", 4'b1110, 2'd0, 1'b1, 1'b0);
    end
    // m0 releases: m3 granted on the same edge, no idle gap.
    set_req(4'b0111);
    tick();
    check("m3_handover", 4'b0111, 2'd3, 1'b1, 1'b0);

    // m3 releases alone: idle, owner keeps 3.
    set_req(4'b1111);
    tick();
    check("m3_release", 4'b1111, 2'd3, 1'b0, 1'b0);

    // New m1 request the next cycle.
    set_req(4'b1101);
    tick();
    check("m1_grant", 4'b1101, 2'd1, 1'b1, 1'b0);

    // m1 holds 20 cycles with m2 waiting: holdErr after the 16th counting edge.
    set_req(4'b1001);
    for (int k = 1; k <= 19; k++) begin
      tick();
      check("m1_hold_m2", 4'b1101, 2'd1, 1'b1, (k >= 16) ? 1'b1 : 1'b0);
    end
    set_req(4'b1011);
    tick();
    check("m2_takeover", 4'b1011, 2'd2, 1'b1, 1'b0);

    // m2 hands to m1; m1 alone holds 20 cycles: no holdErr.
    set_req(4'b1101);
    tick();
    check("m1_again", 4'b1101, 2'd1, 1'b1, 1'b0);
    for (int k = 1; k <= 19; k++) begin
      tick();
      check("m1_alone", 4'b1101, 2'd1, 1'b1, 1'b0);
    end
    set_req(4'b1111);
    tick();
    check("m1_release", 4'b1111, 2'd1, 1'b0, 1'b0);

    // m3 owner, then reset pulsed mid-tenure.
    set_req(4'b0111);
    tick();
    check("m3_grant", 4'b0111, 2'd3, 1'b1, 1'b0);
    tick();
    reset_ = 1'b0;
    #1;
    check("async_rst", 4'b1111, 2'd0, 1'b0, 1'b0);
    tick();
    check("in_rst", 4'b1111, 2'd0, 1'b0, 1'b0);
    reset_ = 1'b1;
    tick();
    check("m3_regrant", 4'b0111, 2'd3, 1'b1, 1'b0);

    // All four requesting; each owner holds 2 cycles, releases one edge.
    for (int k = 0; k < 5; k++) begin
      set_req(rr_rel[k]);
      tick();
      check("rr_grant", rr_grant[k], rr_owner[k], 1'b1, 1'b0);
      set_req(4'b0000);
      tick();
      check("rr_hold", rr_grant[k], rr_owner[k], 1'b1, 1'b0);
    end

    set_req(4'b1111);
    tick();
    check("final_idle", 4'b1111, 2'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
